pipe_stage_regs: RTL and testbench

//   Consumer end of the hazard unit's stall/flush interface. Holds the PC,
//   IF/ID and ID/EX pipeline registers. Applies stallf/stallD/flushD/flushE
//   and branch redirect (pc_sel/pc_target). Supplies Rs1D/Rs2D/RdD back to the

---
 rtl/pipe_stage_regs.sv | 124 ++++++++++++
 tb/tb_pipe_stage_regs.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_regs.sv
// rtl/pipe_stage_regs.sv - PC, IF/ID and ID/EX pipeline registers with stall/flush handling
module pipe_stage_regs #(
  parameter int              SIZE     = 32,
  parameter int              CTRL_W   = 8,
  parameter int              CNT_W    = 16,
  parameter logic [SIZE-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stallf,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              flushE,
  input  logic              pc_sel,
  input  logic [SIZE-1:0]   pc_target,
  input  logic [SIZE-1:0]   instr_F,
  input  logic [CTRL_W-1:0] ctrlD,
  input  logic [SIZE-1:0]   rd1D,
  input  logic [SIZE-1:0]   rd2D,
  input  logic [SIZE-1:0]   immD,
  output logic [SIZE-1:0]   PCF,
  output logic [SIZE-1:0]   instrD,
  output logic [SIZE-1:0]   PCD,
  output logic [SIZE-1:0]   PCplus4D,
  output logic              validD,
  output logic [4:0]        Rs1D,
  output logic [4:0]        Rs2D,
  output logic [4:0]        RdD,
  output logic [CTRL_W-1:0] ctrlE,
  output logic [SIZE-1:0]   rd1E,
  output logic [SIZE-1:0]   rd2E,
  output logic [SIZE-1:0]   immE,
  output logic [SIZE-1:0]   PCE,
  output logic [SIZE-1:0]   PCplus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RDe,
  output logic              validE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [SIZE-1:0] NOP  = SIZE'(32'h0000_0013);
  localparam logic [SIZE-1:0] FOUR = SIZE'(4);

  // A taken branch in EX squashes both younger stages.
  logic bubble_d;
  logic bubble_e;
  logic stall_evt;

  assign bubble_d  = flushD | pc_sel;
  assign bubble_e  = flushE | pc_sel;
  assign stall_evt = stallD & ~bubble_d;

  assign Rs1D = instrD[19:15];
  assign Rs2D = instrD[24:20];
  assign RdD  = instrD[11:7];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PCF <= RESET_PC;
    end else if (pc_sel) begin
      PCF <= pc_target;
    end else if (!stallf) begin
      PCF <= PCF + FOUR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bubble_d) begin
      instrD   <= NOP;
      PCD      <= '0;
      PCplus4D <= '0;
      validD   <= 1'b0;
    end else if (!stallD) begin
      instrD   <= instr_F;
      PCD      <= PCF;
      PCplus4D <= PCF + FOUR;
      validD   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bubble_e) begin
      ctrlE    <= '0;
      rd1E     <= '0;
      rd2E     <= '0;
      immE     <= '0;
      PCE      <= '0;
      PCplus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RDe      <= '0;
      validE   <= 1'b0;
    end else begin
      ctrlE    <= ctrlD;
      rd1E     <= rd1D;
      rd2E     <= rd2D;
      immE     <= immD;
      PCE      <= PCD;
      PCplus4E <= PCplus4D;
      Rs1E     <= instrD[19:15];
      Rs2E     <= instrD[24:20];
      RDe      <= instrD[11:7];
      validE   <= validD;
    end
  end

  // Counters stick at all-ones so long stalls never alias to small counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (bubble_d && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// tb/tb_pipe_stage_regs.sv - randomized self-checking bench for pipe_stage_regs
module tb_pipe_stage_regs;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst_n, stallf, stallD, flushD, flushE, pc_sel;
  logic [31:0] pc_target, instr_F, rd1D, rd2D, immD;
  logic [7:0]  ctrlD;
  logic [31:0] PCF, instrD, PCD, PCplus4D, rd1E, rd2E, immE, PCE, PCplus4E;
  logic        validD, validE;
  logic [4:0]  Rs1D, Rs2D, RdD, Rs1E, Rs2E, RDe;
  logic [7:0]  ctrlE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_stage_regs #(.SIZE(32), .CTRL_W(8), .CNT_W(CNT_W), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stallf(stallf), .stallD(stallD), .flushD(flushD),
    .flushE(flushE), .pc_sel(pc_sel), .pc_target(pc_target), .instr_F(instr_F),
    .ctrlD(ctrlD), .rd1D(rd1D), .rd2D(rd2D), .immD(immD), .PCF(PCF),
    .instrD(instrD), .PCD(PCD), .PCplus4D(PCplus4D), .validD(validD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ctrlE(ctrlE), .rd1E(rd1E),
    .rd2E(rd2E), .immE(immE), .PCE(PCE), .PCplus4E(PCplus4E), .Rs1E(Rs1E),
    .Rs2E(Rs2E), .RDe(RDe), .validE(validE), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural contents of each stage.
  logic [31:0] m_pcf, m_instrD, m_pcd, m_pcp4d;
  logic        m_vd, m_ve;
  logic [7:0]  m_ctrlE;
  logic [31:0] m_rd1E, m_rd2E, m_immE, m_pcE, m_pcp4E;
  logic [4:0]  m_rs1E, m_rs2E, m_rdE;
  int          m_scnt, m_fcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [31:0] i_d;
    if (!rst_n) begin
      m_pcf = 32'h0; m_instrD = 32'h13; m_pcd = 0; m_pcp4d = 0; m_vd = 0;
      m_ctrlE = 0; m_rd1E = 0; m_rd2E = 0; m_immE = 0; m_pcE = 0; m_pcp4E = 0;
      m_rs1E = 0; m_rs2E = 0; m_rdE = 0; m_ve = 0; m_scnt = 0; m_fcnt = 0;
      return;
    end
    i_d = m_instrD;
    if (flushE || pc_sel) begin
      m_ctrlE = 0; m_rd1E = 0; m_rd2E = 0; m_immE = 0; m_pcE = 0; m_pcp4E = 0;
      m_rs1E = 0; m_rs2E = 0; m_rdE = 0; m_ve = 0;
    end else begin
      m_ctrlE = ctrlD; m_rd1E = rd1D; m_rd2E = rd2D; m_immE = immD;
      m_pcE = m_pcd; m_pcp4E = m_pcp4d;
      m_rs1E = i_d[19:15]; m_rs2E = i_d[24:20]; m_rdE = i_d[11:7]; m_ve = m_vd;
    end
    if (flushD || pc_sel) begin
      m_instrD = 32'h13; m_pcd = 0; m_pcp4d = 0; m_vd = 0;
      if (m_fcnt < CNT_MAX) m_fcnt++;
    end else if (!stallD) begin
      m_instrD = instr_F; m_pcd = m_pcf; m_pcp4d = m_pcf + 32'd4; m_vd = 1;
    end else begin
      if (m_scnt < CNT_MAX) m_scnt++;
    end
    if (pc_sel) m_pcf = pc_target;
    else if (!stallf) m_pcf = m_pcf + 32'd4;
  endtask

  task automatic compare_all();
    chk("PCF", PCF, m_pcf);
    chk("instrD", instrD, m_instrD);
    chk("PCD", PCD, m_pcd);
    chk("PCplus4D", PCplus4D, m_pcp4d);
    chk("validD", 32'(validD), 32'(m_vd));
    chk("Rs1D", 32'(Rs1D), 32'(m_instrD[19:15]));
    chk("Rs2D", 32'(Rs2D), 32'(m_instrD[24:20]));
    chk("RdD", 32'(RdD), 32'(m_instrD[11:7]));
    chk("ctrlE", 32'(ctrlE), 32'(m_ctrlE));
    chk("rd1E", rd1E, m_rd1E);
    chk("rd2E", rd2E, m_rd2E);
    chk("immE", immE, m_immE);
    chk("PCE", PCE, m_pcE);
    chk("PCplus4E", PCplus4E, m_pcp4E);
    chk("Rs1E", 32'(Rs1E), 32'(m_rs1E));
    chk("Rs2E", 32'(Rs2E), 32'(m_rs2E));
    chk("RDe", 32'(RDe), 32'(m_rdE));
    chk("validE", 32'(validE), 32'(m_ve));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    rst_n = 1; stallf = 0; stallD = 0; flushD = 0; flushE = 0; pc_sel = 0;
  endtask

  initial begin
    idle_inputs();
    pc_target = 0; instr_F = 32'h00A00093; ctrlD = 8'h5A;
    rd1D = 32'h11; rd2D = 32'h22; immD = 32'h33;
    #1;

    // Reset, then free-running fetch.
    rst_n = 0; step();
    chk("rst PCF", PCF, 32'h0);
    chk("rst instrD", instrD, 32'h13);
    chk("rst validD", 32'(validD), 32'd0);
    chk("rst validE", 32'(validE), 32'd0);
    rst_n = 1; step();
    chk("free1 PCF", PCF, 32'd4);
    chk("free1 validD", 32'(validD), 32'd1);
    chk("free1 Rs1D", 32'(Rs1D), 32'd0);
    chk("free1 RdD", 32'(RdD), 32'd1);
    step();
    chk("free2 PCF", PCF, 32'd8);
    chk("free2 validE", 32'(validE), 32'd1);
    chk("free2 RDe", 32'(RDe), 32'd1);

    // Load-use: F and D hold, E bubbles.
    stallf = 1; stallD = 1; flushE = 1; step();
    chk("ldu PCF", PCF, 32'd8);
    chk("ldu instrD", instrD, 32'h00A00093);
    chk("ldu validE", 32'(validE), 32'd0);
    chk("ldu RDe", 32'(RDe), 32'd0);
    chk("ldu ctrlE", 32'(ctrlE), 32'd0);
    chk("ldu stall_cnt", 32'(stall_cnt), 32'd1);

    // Redirect wins over stallf.
    idle_inputs(); stallf = 1; pc_sel = 1; pc_target = 32'h100; step();
    chk("br PCF", PCF, 32'h100);
    chk("br validD", 32'(validD), 32'd0);
    chk("br instrD", instrD, 32'h13);
    chk("br validE", 32'(validE), 32'd0);
    chk("br flush_cnt", 32'(flush_cnt), 32'd1);

    // PC wraps.
    idle_inputs(); pc_sel = 1; pc_target = 32'hFFFF_FFFC; step();
    chk("wrap0 PCF", PCF, 32'hFFFF_FFFC);
    idle_inputs(); step();
    chk("wrap1 PCF", PCF, 32'h0);
    chk("wrap1 PCplus4D", PCplus4D, 32'h0);

    // Reset in the middle of a stall.
    stallf = 1; stallD = 1; step();
    rst_n = 0; step();
    chk("rst2 PCF", PCF, 32'h0);
    chk("rst2 validD", 32'(validD), 32'd0);
    chk("rst2 validE", 32'(validE), 32'd0);
    chk("rst2 stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst2 flush_cnt", 32'(flush_cnt), 32'd0);

    // Saturation of the stall counter.
    rst_n = 1; stallD = 1; stallf = 1;
    for (int i = 0; i < (1 << CNT_W) + 5; i++) step();
    chk("sat stall_cnt", 32'(stall_cnt), 32'd15);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 99) >= 2);
      stallf    = ($urandom_range(0, 3) == 0);
      stallD    = ($urandom_range(0, 3) == 0);
      flushD    = ($urandom_range(0, 7) == 0);
      flushE    = ($urandom_range(0, 5) == 0);
      pc_sel    = ($urandom_range(0, 9) == 0);
      pc_target = {$urandom} & 32'hFFFF_FFFC;
      instr_F   = $urandom;
      ctrlD     = 8'($urandom);
      rd1D      = $urandom;
      rd2D      = $urandom;
      immD      = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
